// File: rtl/onehot_dec_pkg.sv
// Shared encodings for the pipelined one-hot / thermometer / sweep decoder.
package onehot_dec_pkg;

  localparam logic [1:0] MODE_ONEHOT  = 2'b00;
  localparam logic [1:0] MODE_THERM   = 2'b01;
  localparam logic [1:0] MODE_SWEEP   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_decoder_pipe_if.sv
// Request/beat bus of the decoder; the slave modport is the decoder side.
interface onehot_decoder_pipe_if #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 4
);
  localparam int OUT_W = 1 << IN_W;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid && ready; valid never waits on ready, and a raised valid keeps its
  // payload stable until the transfer.
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic [1:0]       in_mode;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dec_out;
  logic             out_last;
  logic             err_mode;

  modport slave (
    input  in_valid, in_code, in_mode, in_count, out_ready,
    output in_ready, out_valid, dec_out, out_last, err_mode
  );

  modport master (
    output in_valid, in_code, in_mode, in_count, out_ready,
    input  in_ready, out_valid, dec_out, out_last, err_mode
  );

endinterface

// File: rtl/onehot_vec_gen.sv
// Combinational (code, mode) -> select vector; sweep beats decode as one-hot.
module onehot_vec_gen
  import onehot_dec_pkg::*;
#(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]        code,
  input  logic [1:0]             mode,
  output logic [(1<<IN_W)-1:0]   vec
);

  localparam int OUT_W = 1 << IN_W;

  always_comb begin
    vec = '0;
    case (mode)
      MODE_ONEHOT, MODE_SWEEP: vec[code] = 1'b1;
      MODE_THERM: begin
        for (int i = 0; i < OUT_W; i++) begin
          vec[i] = (IN_W'(i) <= code);
        end
      end
      default: vec = '0;
    endcase
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered decoder: one-hot, thermometer or multi-beat wrapping sweep behind valid/ready.
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_pipe_if.slave bus,
  output state_t               dbg_state
);

  localparam int OUT_W = 1 << IN_W;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  code_q, code_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] beat_nxt;
  logic [IN_W-1:0]  gen_code;
  logic [1:0]       gen_mode;
  logic [OUT_W-1:0] gen_vec;

  assign in_ready = !valid_q || (bus.out_ready && last_q);
  assign accept   = bus.in_valid && in_ready;
  assign beat_nxt = beat_q + CNT_W'(1);

  // One generator serves both a fresh request and the next sweep beat; the
  // truncating add gives the wrap modulo OUT_W for free.
  assign gen_code = accept ? bus.in_code : code_q + IN_W'(beat_nxt);
  assign gen_mode = accept ? bus.in_mode : MODE_SWEEP;

  onehot_vec_gen #(.IN_W(IN_W)) u_vec_gen (
    .code (gen_code),
    .mode (gen_mode),
    .vec  (gen_vec)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    dec_d   = dec_q;
    last_d  = last_q;
    err_d   = err_q;
    if (accept) begin
      state_d = ST_EMIT;
      code_d  = bus.in_code;
      count_d = bus.in_count;
      beat_d  = '0;
      valid_d = 1'b1;
      dec_d   = gen_vec;
      last_d  = (bus.in_mode != MODE_SWEEP) || (bus.in_count == '0);
      if (bus.in_mode == MODE_ILLEGAL) err_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (last_q) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              dec_d   = '0;
              last_d  = 1'b0;
            end else begin
              beat_d = beat_nxt;
              dec_d  = gen_vec;
              last_d = (beat_nxt == count_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.dec_out   = dec_q;
  assign bus.out_last  = last_q;
  assign bus.err_mode  = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: vector table, directed corner sequences, random vs. beat-queue model.
module tb_onehot_decoder_pipe;
  import onehot_dec_pkg::*;

  localparam int IN_W  = 4;
  localparam int CNT_W = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;

  // Each entry is {last, vec} for one beat still owed by the DUT.
  logic [16:0] exp_q[$];
  logic        exp_err = 1'b0;

  onehot_decoder_pipe_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();

  onehot_decoder_pipe #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [1:0]  mode;
    logic [15:0] exp_vec;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] code, input logic [1:0] mode,
                       input logic [3:0] count, input logic ordy);
    bus.in_valid  = v;
    bus.in_code   = code;
    bus.in_mode   = mode;
    bus.in_count  = count;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic model_push(input logic [3:0] code, input logic [1:0] mode, input logic [3:0] count);
    logic [31:0] v;
    case (mode)
      2'b00: begin v = 32'd1 << code; exp_q.push_back({1'b1, v[15:0]}); end
      2'b01: begin v = (32'd2 << code) - 32'd1; exp_q.push_back({1'b1, v[15:0]}); end
      2'b10: begin
        for (int k = 0; k <= int'(count); k++) begin
          v = 32'd1 << ((int'(code) + k) % 16);
          exp_q.push_back({(k == int'(count)), v[15:0]});
        end
      end
      default: begin exp_q.push_back({1'b1, 16'h0000}); exp_err = 1'b1; end
    endcase
  endtask

  // Compare outputs against the model, then take one clock edge and advance the model.
  task automatic cycle();
    logic        exp_rdy;
    logic [16:0] f;
    #1;
    exp_rdy = (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1);
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      f = exp_q[0];
      check("dec_out", 32'(bus.dec_out), 32'(f[15:0]));
      check("out_last", 32'(bus.out_last), 32'(f[16]));
    end
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("err_mode", 32'(bus.err_mode), 32'(exp_err));
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && exp_rdy) model_push(bus.in_code, bus.in_mode, bus.in_count);
    end
    #1;
  endtask

  initial begin
    tbl[0] = '{4'd9,  MODE_ONEHOT, 16'h0200};
    tbl[1] = '{4'd0,  MODE_ONEHOT, 16'h0001};
    tbl[2] = '{4'd15, MODE_ONEHOT, 16'h8000};
    tbl[3] = '{4'd3,  MODE_THERM,  16'h000F};
    tbl[4] = '{4'd0,  MODE_THERM,  16'h0001};
    tbl[5] = '{4'd15, MODE_THERM,  16'hFFFF};
    tbl[6] = '{4'd7,  MODE_THERM,  16'h00FF};
    tbl[7] = '{4'd5,  MODE_SWEEP,  16'h0020};

    // Reset state
    drive(0, 0, 0, 0, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_dec_out", 32'(bus.dec_out), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_err_mode", 32'(bus.err_mode), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Single-beat vector table (sweep with count 0 behaves as one-hot)
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].code, tbl[i].mode, 4'd0, 1);
      cycle();
      drive(0, 0, 0, 0, 1);
      check("tbl_valid", 32'(bus.out_valid), 1);
      check("tbl_vec", 32'(bus.dec_out), 32'(tbl[i].exp_vec));
      check("tbl_last", 32'(bus.out_last), 1);
      check("tbl_ready", 32'(bus.in_ready), 1);
      cycle();
    end

    // Thermometer under backpressure
    drive(1, 4'd3, MODE_THERM, 0, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd12, MODE_ONEHOT, 0, 0);
      check("bp_hold_vec", 32'(bus.dec_out), 32'h000F);
      check("bp_ready_low", 32'(bus.in_ready), 0);
      cycle();
    end
    drive(0, 0, 0, 0, 1);
    check("bp_release_ready", 32'(bus.in_ready), 1);
    cycle();
    check("bp_retired", 32'(bus.out_valid), 0);

    // Sweep wrapping past bit 15
    drive(1, 4'd14, MODE_SWEEP, 4'd3, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    check("sw_b0", 32'(bus.dec_out), 32'h4000);
    check("sw_b0_last", 32'(bus.out_last), 0);
    check("sw_b0_ready", 32'(bus.in_ready), 0);
    cycle();
    check("sw_b1", 32'(bus.dec_out), 32'h8000);
    check("sw_b1_ready", 32'(bus.in_ready), 0);
    cycle();
    check("sw_b2", 32'(bus.dec_out), 32'h0001);
    check("sw_b2_last", 32'(bus.out_last), 0);
    cycle();
    check("sw_b3", 32'(bus.dec_out), 32'h0002);
    check("sw_b3_last", 32'(bus.out_last), 1);
    check("sw_b3_ready", 32'(bus.in_ready), 1);
    cycle();

    // Back-to-back one-hot, no bubbles
    drive(1, 4'd0, MODE_ONEHOT, 0, 1);
    cycle();
    drive(1, 4'd1, MODE_ONEHOT, 0, 1);
    check("b2b_0", 32'(bus.dec_out), 32'h0001);
    cycle();
    drive(1, 4'd2, MODE_ONEHOT, 0, 1);
    check("b2b_1", 32'(bus.dec_out), 32'h0002);
    cycle();
    drive(0, 0, 0, 0, 1);
    check("b2b_2", 32'(bus.dec_out), 32'h0004);
    check("b2b_2_valid", 32'(bus.out_valid), 1);
    cycle();

    // Illegal mode, then sticky error across a legal request
    drive(1, 4'd5, MODE_ILLEGAL, 0, 1);
    cycle();
    drive(1, 4'd1, MODE_ONEHOT, 0, 1);
    check("ill_vec", 32'(bus.dec_out), 32'h0000);
    check("ill_last", 32'(bus.out_last), 1);
    check("ill_err", 32'(bus.err_mode), 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    check("ill_next_vec", 32'(bus.dec_out), 32'h0002);
    check("ill_err_sticky", 32'(bus.err_mode), 1);
    cycle();

    // Reset in the middle of a sweep
    drive(1, 4'd0, MODE_SWEEP, 4'd7, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    cycle();
    check("mid_b2", 32'(bus.dec_out), 32'h0004);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("mid_valid", 32'(bus.out_valid), 0);
    check("mid_dec", 32'(bus.dec_out), 0);
    check("mid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_ready", 32'(bus.in_ready), 1);
    check("mid_err", 32'(bus.err_mode), 0);
    cycle();

    // Random traffic against the beat-queue model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
